// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter: grant encoding and address-width helper.
package bram_port_arbiter_pkg;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_e;

    // Number of bits needed to represent value (clogb2(2047) = 11).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 32'sd0;
        while (v > 32'sd0) begin
            n = n + 32'sd1;
            v = v >>> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_true_sync_dpbram.sv
// Synchronous true dual-port block RAM; dout only changes on a read of that port.
module true_sync_dpbram
    import bram_port_arbiter_pkg::*;
#(
    parameter  int DWIDTH   = 64,
    parameter  int MEM_SIZE = 2048,
    localparam int AWIDTH   = clogb2(MEM_SIZE - 1)
) (
    input  logic              clk,
    input  logic              ce_a,
    input  logic              we_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] din_a,
    output logic [DWIDTH-1:0] dout_a,
    input  logic              ce_b,
    input  logic              we_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0] din_b,
    output logic [DWIDTH-1:0] dout_b
);

    logic [DWIDTH-1:0] mem_r [MEM_SIZE];
    logic [DWIDTH-1:0] dout_a_r;
    logic [DWIDTH-1:0] dout_b_r;

    // Both ports share one process so the array has a single driver; B wins a write collision.
    always_ff @(posedge clk) begin
        if (ce_a) begin
            if (we_a) begin
                mem_r[addr_a] <= din_a;
            end else begin
                dout_a_r <= mem_r[addr_a];
            end
        end
        if (ce_b) begin
            if (we_b) begin
                mem_r[addr_b] <= din_b;
            end else begin
                dout_b_r <= mem_r[addr_b];
            end
        end
    end

    assign dout_a = dout_a_r;
    assign dout_b = dout_b_r;

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between a write requester and a read requester
// with a 1-cycle read return that holds under consumer backpressure.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter  int DWIDTH   = 64,
    parameter  int MEM_SIZE = 2048,
    localparam int AWIDTH   = clogb2(MEM_SIZE - 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DWIDTH-1:0] rdata
);

    logic              rdata_valid_r;
    grant_e            last_grant_r;
    logic              rd_ok_s;
    logic              wr_elig_s;
    logic              rd_elig_s;
    logic              contend_s;
    logic              wr_gnt_s;
    logic              rd_gnt_s;
    logic              ram_ce_s;
    logic              ram_we_s;
    logic [AWIDTH-1:0] ram_addr_s;
    logic [DWIDTH-1:0] ram_dout_s;
    logic [DWIDTH-1:0] unused_dout_b;

    // A read may only issue when the return slot is empty or being drained this cycle.
    assign rd_ok_s   = !rdata_valid_r || rdata_ready;
    assign wr_elig_s = wr_valid;
    assign rd_elig_s = rd_valid && rd_ok_s;
    assign contend_s = wr_elig_s && rd_elig_s;

    // Grant selection: lone requester goes straight through, contention alternates.
    always_comb begin
        wr_gnt_s = 1'b0;
        rd_gnt_s = 1'b0;
        if (reset) begin
            wr_gnt_s = 1'b0;
            rd_gnt_s = 1'b0;
        end else if (contend_s) begin
            case (last_grant_r)
                GNT_READ:  wr_gnt_s = 1'b1;
                GNT_WRITE: rd_gnt_s = 1'b1;
                default:   wr_gnt_s = 1'b1;
            endcase
        end else begin
            wr_gnt_s = wr_elig_s;
            rd_gnt_s = rd_elig_s;
        end
    end

    // Return-valid tracking and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_valid_r <= 1'b0;
            last_grant_r  <= GNT_READ;
        end else begin
            if (rd_gnt_s) begin
                rdata_valid_r <= 1'b1;
            end else if (rdata_ready) begin
                rdata_valid_r <= 1'b0;
            end else begin
                rdata_valid_r <= rdata_valid_r;
            end
            if (contend_s) begin
                last_grant_r <= wr_gnt_s ? GNT_WRITE : GNT_READ;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign ram_ce_s   = wr_gnt_s || rd_gnt_s;
    assign ram_we_s   = wr_gnt_s;
    assign ram_addr_s = wr_gnt_s ? wr_addr : rd_addr;

    true_sync_dpbram #(
        .DWIDTH   (DWIDTH),
        .MEM_SIZE (MEM_SIZE)
    ) u_ram (
        .clk    (clk),
        .ce_a   (ram_ce_s),
        .we_a   (ram_we_s),
        .addr_a (ram_addr_s),
        .din_a  (wr_data),
        .dout_a (ram_dout_s),
        .ce_b   (1'b0),
        .we_b   (1'b0),
        .addr_b ({AWIDTH{1'b0}}),
        .din_b  ({DWIDTH{1'b0}}),
        .dout_b (unused_dout_b)
    );

    assign wr_ready    = wr_gnt_s;
    assign rd_ready    = rd_gnt_s;
    assign rdata_valid = rdata_valid_r;
    assign rdata       = ram_dout_s;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed plus randomized bench for bram_port_arbiter against a transaction-level reference model.
module tb_bram_port_arbiter;

    localparam int DW = 64;
    localparam int MS = 2048;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] rdata;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: memory image, pending-return flag/word, and who won the last contention.
    logic [DW-1:0] m_mem [MS];
    bit            m_rv;
    bit            m_last_rd;
    logic [DW-1:0] m_rd;

    logic          obs_w;
    logic          obs_r;
    logic          obs_rv;
    logic [DW-1:0] obs_rdata;

    bram_port_arbiter #(.DWIDTH(DW), .MEM_SIZE(MS)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied at negedge, check, advance model, move to next negedge.
    task automatic step(input string tag);
        bit ew, er, wv, rv, rok;
        ew = 1'b0; er = 1'b0; wv = 1'b0; rv = 1'b0;
        #1;
        if (reset === 1'b1) begin
            m_rv      = 1'b0;
            m_last_rd = 1'b1;
        end else begin
            rok = !m_rv || (rdata_ready === 1'b1);
            wv  = (wr_valid === 1'b1);
            rv  = (rd_valid === 1'b1) && rok;
            if (wv && rv) begin
                ew = m_last_rd;
                er = !m_last_rd;
            end else begin
                ew = wv;
                er = rv;
            end
        end
        obs_w = wr_ready; obs_r = rd_ready; obs_rv = rdata_valid; obs_rdata = rdata;
        chk1({tag, ".wr_ready"}, wr_ready, ew);
        chk1({tag, ".rd_ready"}, rd_ready, er);
        chk1({tag, ".rdata_valid"}, rdata_valid, m_rv);
        if (m_rv) chk64({tag, ".rdata"}, rdata, m_rd);
        if (reset !== 1'b1) begin
            if (wv && rv) m_last_rd = er;
            if (ew) m_mem[wr_addr] = wr_data;
            if (er) begin
                m_rd = m_mem[rd_addr];
                m_rv = 1'b1;
            end else if (rdata_ready === 1'b1) begin
                m_rv = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int vcount;
        logic pat;
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rdata_ready = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        m_rv = 1'b0; m_last_rd = 1'b1; m_rd = '0;
        @(negedge clk);

        // Reset holds both readies low even with both requesters pending.
        wr_valid = 1'b1; rd_valid = 1'b1;
        step("rst");
        step("rst");
        chk1("rst.rdata_valid", obs_rv, 1'b0);

        // Contention straight out of reset: W,R,W,R; reads see the write of the previous cycle.
        reset = 1'b0; wr_addr = 11'd3; rd_addr = 11'd3;
        for (int i = 0; i < 4; i++) begin
            wr_data = 64'h0000_0000_0000_00A0 + 64'(i);
            step("contend");
            pat = (i % 2 == 0);
            chk1("contend.order", obs_w, pat);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        step("contend.tail");

        // Single write then read at address 5.
        wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 64'h0123_4567_89AB_CDEF;
        step("w5");
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 11'd5;
        step("r5");
        rd_valid = 1'b0;
        step("r5.ret");
        chk1("r5.valid", obs_rv, 1'b1);
        chk64("r5.data", obs_rdata, 64'h0123_4567_89AB_CDEF);

        // Backpressure: held return word blocks further reads until drained.
        wr_valid = 1'b1; wr_addr = 11'd7; wr_data = 64'h7777_0000_DEAD_BEEF;
        step("w7");
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 11'd7;
        step("r7");
        rdata_ready = 1'b0; rd_addr = 11'd5;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk1("bp.rd_ready", obs_r, 1'b0);
            chk64("bp.rdata", obs_rdata, 64'h7777_0000_DEAD_BEEF);
        end
        rdata_ready = 1'b1;
        step("bp.release");
        chk1("bp.release_grant", obs_r, 1'b1);
        rd_valid = 1'b0;
        step("bp.tail");

        // Reset pulsed the cycle after a read grant drops it; memory survives.
        rd_valid = 1'b1; rd_addr = 11'd5;
        step("rr.grant");
        rd_valid = 1'b0; reset = 1'b1;
        step("rr.reset");
        chk1("rr.dropped", obs_rv, 1'b0);
        reset = 1'b0;
        step("rr.idle");
        rd_valid = 1'b1;
        step("rr.reread");
        rd_valid = 1'b0;
        step("rr.ret");
        chk64("rr.data", obs_rdata, 64'h0123_4567_89AB_CDEF);

        // Streaming: fill 0..15 then read them back at one per cycle.
        wr_valid = 1'b1;
        for (int a = 0; a < 16; a++) begin
            wr_addr = AW'(a);
            wr_data = 64'hC0DE_0000_0000_0000 | 64'(a);
            step("fill");
        end
        wr_valid = 1'b0; rd_valid = 1'b1; vcount = 0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = AW'(a);
            step("stream");
            if (obs_rv === 1'b1) vcount++;
            if (a > 0) chk64("stream.order", obs_rdata, 64'hC0DE_0000_0000_0000 | 64'(a - 1));
        end
        rd_valid = 1'b0;
        step("stream.tail");
        if (obs_rv === 1'b1) vcount++;
        chk64("stream.order_last", obs_rdata, 64'hC0DE_0000_0000_000F);
        n_assert++;
        assert (vcount == 16) else begin
            n_fail++;
            $error("FAIL stream.valid_count: observed %0d expected 16", vcount);
        end

        // Randomized traffic over the populated region.
        for (int i = 0; i < 400; i++) begin
            wr_valid    = 1'($urandom_range(0, 1));
            rd_valid    = 1'($urandom_range(0, 1));
            rdata_ready = ($urandom_range(0, 3) != 0);
            wr_addr     = AW'($urandom_range(0, 15));
            rd_addr     = AW'($urandom_range(0, 15));
            wr_data     = {$urandom, $urandom};
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning data word width in bits.
REQ-002 SHALL have parameter MEM_SIZE, default 2048, meaning depth in words; AWIDTH = clogb2(MEM_SIZE-1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port wr_valid, input, 1, meaning the write requester has a word pending.
REQ-006 SHALL have port wr_ready, output, 1, meaning the write is granted this cycle.
REQ-007 SHALL have port wr_addr, input, AWIDTH, meaning the write address.
REQ-008 SHALL have port wr_data, input, DWIDTH, meaning the write data.
REQ-009 SHALL have port rd_valid, input, 1, meaning the read requester has an address pending.
REQ-010 SHALL have port rd_ready, output, 1, meaning the read is granted this cycle.
REQ-011 SHALL have port rd_addr, input, AWIDTH, meaning the read address.
REQ-012 SHALL have port rdata_valid, output, 1, meaning rdata holds a returned word.
REQ-013 SHALL have port rdata_ready, input, 1, meaning the consumer takes rdata this cycle.
REQ-014 SHALL have port rdata, output, DWIDTH, meaning the read return data.

Function
REQ-015 SHALL perform at most one RAM access per cycle; a transfer occurs when valid & ready are both high.
REQ-016 SHALL compute rd_ok = !rdata_valid | rdata_ready; a read is eligible only when rd_valid & rd_ok.
REQ-017 SHALL drive wr_ready and rd_ready combinationally from valids, rd_ok and last_grant; ready SHALL NOT depend on the same port's address or data.
REQ-018 SHALL grant a lone eligible requester immediately.
REQ-019 SHALL arbitrate round-robin when write and read are both eligible: grant the side not in last_grant, then set last_grant to the granted side.
REQ-020 SHALL update last_grant only on a contended grant; uncontended grants leave it unchanged.
REQ-021 SHALL, on a write transfer, drive RAM ce=1, we=1, addr=wr_addr, din=wr_data in the same cycle.
REQ-022 SHALL, on a read transfer, drive RAM ce=1, we=0, addr=rd_addr; rdata_valid rises on the next edge, giving 1-cycle latency.
REQ-023 SHALL hold rdata and rdata_valid stable while rdata_valid & !rdata_ready; RAM dout changes only on a read, so no extra buffer is required.
REQ-024 SHALL clear rdata_valid on an edge where rdata_ready=1 and no new read transferred; it stays 1 on back-to-back reads, sustaining 1 read/cycle.
REQ-025 SHALL return new data for a read granted one or more cycles after a write to the same address; same-cycle conflict is impossible because only one port is granted.
REQ-026 SHALL drive ce=0 when nothing is granted.
REQ-027 SHALL treat address values at or above MEM_SIZE as undefined behaviour; no wrap or check is required.

Reset
REQ-028 SHALL, while reset=1, force rdata_valid=0, last_grant=READ (the first contention goes to write), wr_ready=0 and rd_ready=0.
REQ-029 SHALL drop a read in flight when reset asserts mid-operation; RAM contents are retained and not cleared.
REQ-030 SHALL leave rdata undefined until the first read after reset; it is don't-care while rdata_valid=0.

Structure
REQ-031 SHALL place clogb2 and the grant encoding constants (GNT_WRITE, GNT_READ) in the shared package.
REQ-032 SHALL instantiate exactly one true_sync_dpbram(DWIDTH, MEM_SIZE) as the storage sub-module; the arbiter contains no other memory.

Verification
REQ-033 SHALL cover single write then read: write 0x0123456789ABCDEF at addr 5; next cycle read 5 -> rdata_valid one cycle later, rdata = 0x0123456789ABCDEF.
REQ-034 SHALL cover contention from reset: wr_valid & rd_valid held high for 4 cycles -> grants W,R,W,R.
REQ-035 SHALL cover backpressure: read addr 7, rdata_ready=0 for 3 cycles with rd_valid high -> rd_ready=0, rdata stable for 3 cycles; then rdata_ready=1 -> the next read is granted in that same cycle.
REQ-036 SHALL cover streaming: reads of addrs 0..15 with rdata_ready=1 -> 16 consecutive rdata_valid cycles, data in address order.
REQ-037 SHALL cover reset mid-read: reset pulsed the cycle after a read grant -> rdata_valid=0; rereading the address returns the data written before reset.
